// File: rtl/spi_pkg.sv
// Shared definitions for the byte-oriented SPI master: register offsets,
// CTRL/STATUS bit positions, FSM encoding and bit-order helper.
package spi_pkg;

  // Register offsets within the four-byte window
  localparam logic [1:0] AddrData = 2'd0;
  localparam logic [1:0] AddrCtrl = 2'd1;
  localparam logic [1:0] AddrCs   = 2'd2;
  localparam logic [1:0] AddrDiv  = 2'd3;

  // CTRL read/write bits
  localparam int unsigned CtrlCpol     = 0;
  localparam int unsigned CtrlCpha     = 1;
  localparam int unsigned CtrlIrqEn    = 2;
  localparam int unsigned CtrlLsbFirst = 3;

  // CTRL read-only status bits
  localparam int unsigned StatOvr  = 5;
  localparam int unsigned StatDone = 6;
  localparam int unsigned StatBusy = 7;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLead,
    StTrail,
    StFin
  } spi_state_e;

  // Position within the byte of the k-th bit on the wire
  function automatic logic [2:0] bit_idx(input logic [2:0] k, input logic lsb_first);
    return lsb_first ? k : (3'd7 - k);
  endfunction

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator: reloads from i_div while disabled and after
// each tick, so every enabled half-period lasts i_div+1 clock cycles.
module spi_clkdiv #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Down-counter with reload on disable or terminal count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_tick) begin
      r_cnt <= i_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte-oriented SPI master: CPU register file, transfer FSM and shifter.
// A DATA write while idle runs one 8-bit transfer in hardware.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned NCS   = 4,
  parameter int unsigned DIV_W = 8
) (
  input  logic           MHZ48,
  input  logic           RES,
  input  logic [1:0]     ADDR,
  input  logic           WE,
  input  logic           RE,
  input  logic [7:0]     DIN,
  output logic [7:0]     DOUT,
  output logic           SCLK,
  output logic           MOSI,
  input  logic           MISO,
  output logic [NCS-1:0] nCS,
  output logic           BUSY,
  output logic           IRQ
);

  spi_state_e r_state;

  // CPU-visible registers
  logic [3:0]       r_ctrl;
  logic [NCS-1:0]   r_cs;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_tx;
  logic [7:0]       r_rx;
  logic [7:0]       r_dout;
  logic             r_done;
  logic             r_ovr;

  // Transfer state and working copies taken at LOAD
  logic             r_busy;
  logic             r_sclk;
  logic             r_mosi;
  logic [2:0]       r_bit;
  logic             r_cpha_l;
  logic             r_lsb_l;
  logic [DIV_W-1:0] r_div_l;
  logic [7:0]       r_rxsh;

  logic             w_wr_data;
  logic             w_rd_data;
  logic             w_start;
  logic             w_overrun;
  logic             w_en;
  logic             w_tick;
  logic [DIV_W-1:0] w_div_sel;
  logic [2:0]       w_idx;
  logic [2:0]       w_idx_next;
  logic [7:0]       w_cs_rd;
  logic [7:0]       w_div_rd;
  logic [7:0]       w_rd_mux;

  assign w_wr_data  = WE && (ADDR == AddrData);
  assign w_rd_data  = RE && (ADDR == AddrData);
  // Any non-idle state, FIN included, rejects a new DATA write
  assign w_start    = w_wr_data && (r_state == StIdle);
  assign w_overrun  = w_wr_data && (r_state != StIdle);
  assign w_en       = (r_state == StLead) || (r_state == StTrail);
  // The counter preloads during LOAD, before the working copy is valid
  assign w_div_sel  = (r_state == StLoad) ? r_div : r_div_l;
  assign w_idx      = bit_idx(r_bit, r_lsb_l);
  assign w_idx_next = bit_idx(r_bit + 3'd1, r_lsb_l);

  spi_clkdiv #(
    .DIV_W (DIV_W)
  ) u_clkdiv (
    .i_clk  (MHZ48),
    .i_rst  (RES),
    .i_en   (w_en),
    .i_div  (w_div_sel),
    .o_tick (w_tick)
  );

  // Read data multiplexer, unused register bits read as zero
  always_comb begin
    w_cs_rd             = '0;
    w_cs_rd[NCS-1:0]    = r_cs;
    w_div_rd            = '0;
    w_div_rd[DIV_W-1:0] = r_div;
    w_rd_mux            = '0;
    case (ADDR)
      AddrData: w_rd_mux = r_rx;
      AddrCtrl: w_rd_mux = {r_busy, r_done, r_ovr, 1'b0, r_ctrl};
      AddrCs:   w_rd_mux = w_cs_rd;
      AddrDiv:  w_rd_mux = w_div_rd;
      default:  w_rd_mux = '0;
    endcase
  end

  // CPU register writes and registered read data
  always_ff @(posedge MHZ48 or posedge RES) begin
    if (RES) begin
      r_ctrl <= '0;
      r_cs   <= '1;
      r_div  <= '0;
      r_tx   <= '0;
      r_dout <= '0;
    end else begin
      if (WE) begin
        case (ADDR)
          AddrData: if (w_start) r_tx <= DIN;
          AddrCtrl: r_ctrl <= DIN[3:0];
          AddrCs:   r_cs   <= DIN[NCS-1:0];
          AddrDiv:  r_div  <= DIN[DIV_W-1:0];
          default:  ;
        endcase
      end
      if (RE) begin
        r_dout <= w_rd_mux;
      end
    end
  end

  // Transfer FSM, shifter and DONE/OVR status flags
  always_ff @(posedge MHZ48 or posedge RES) begin
    if (RES) begin
      r_state  <= StIdle;
      r_busy   <= 1'b0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_bit    <= '0;
      r_cpha_l <= 1'b0;
      r_lsb_l  <= 1'b0;
      r_div_l  <= '0;
      r_rxsh   <= '0;
      r_rx     <= '0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      // A completion landing in the same cycle as a DATA read keeps DONE set
      if (w_rd_data) begin
        r_ovr <= 1'b0;
        if (r_state != StFin) r_done <= 1'b0;
      end
      if (w_overrun) r_ovr <= 1'b1;

      unique case (r_state)
        StIdle: begin
          r_sclk <= r_ctrl[CtrlCpol];
          if (w_start) begin
            r_state <= StLoad;
            r_busy  <= 1'b1;
          end
        end
        StLoad: begin
          // SCLK level set here doubles as the latched CPOL for this byte
          r_sclk   <= r_ctrl[CtrlCpol];
          r_cpha_l <= r_ctrl[CtrlCpha];
          r_lsb_l  <= r_ctrl[CtrlLsbFirst];
          r_div_l  <= r_div;
          r_bit    <= '0;
          if (!r_ctrl[CtrlCpha]) begin
            r_mosi <= r_tx[bit_idx(3'd0, r_ctrl[CtrlLsbFirst])];
          end
          r_state <= StLead;
        end
        StLead: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (r_cpha_l) r_mosi <= r_tx[w_idx];
            else          r_rxsh[w_idx] <= MISO;
            r_state <= StTrail;
          end
        end
        StTrail: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (r_cpha_l)            r_rxsh[w_idx] <= MISO;
            else if (r_bit != 3'd7)  r_mosi <= r_tx[w_idx_next];
            if (r_bit == 3'd7) begin
              r_state <= StFin;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_state <= StLead;
            end
          end
        end
        StFin: begin
          r_sclk  <= r_ctrl[CtrlCpol];
          r_rx    <= r_rxsh;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign DOUT = r_dout;
  assign SCLK = r_sclk;
  assign MOSI = r_mosi;
  assign nCS  = r_cs;
  assign BUSY = r_busy;
  assign IRQ  = r_done & r_ctrl[CtrlIrqEn];

endmodule
